// File: rtl/if_fetch_master.sv
// AXI4-Lite instruction fetch master: one read outstanding at most, feeding a
// single instruction per transaction to the fetch stage with flush/stall handling.
module if_fetch_master #(
    parameter logic [31:0] RESET_INST = 32'h00000013
) (
    input  logic        ACLK,
    input  logic        ARESETn,
    input  logic [31:0] pc_i,
    input  logic        pipe_stall_i,
    input  logic        flush_i,
    output logic [31:0] ARADDR,
    output logic [2:0]  ARPROT,
    output logic        ARVALID,
    input  logic        ARREADY,
    input  logic [31:0] RDATA,
    input  logic [1:0]  RRESP,
    input  logic        RVALID,
    output logic        RREADY,
    output logic [31:0] instruction_o,
    output logic        inst_valid_o,
    output logic        fetch_stall_o,
    output logic        fault_o
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ADDR = 2'b01,
        DATA = 2'b10,
        DONE = 2'b11
    } state_t;

    state_t      state;
    logic [31:0] addr_q;
    logic [31:0] inst_q;
    logic        fault_q;
    logic        drop_q;
    logic        ar_valid_q;
    logic        r_ready_q;
    logic        unused_pc_bits;

    // Fetch sequencer; handshake outputs are registered so they only change on ACLK.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state      <= IDLE;
            addr_q     <= 32'h0000_0000;
            inst_q     <= RESET_INST;
            fault_q    <= 1'b0;
            drop_q     <= 1'b0;
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!flush_i) begin
                        addr_q     <= {pc_i[31:2], 2'b00};
                        ar_valid_q <= 1'b1;
                        state      <= ADDR;
                    end
                end
                ADDR: begin
                    // A flush cannot retract ARVALID; remember it and drop the data later.
                    if (flush_i) begin
                        drop_q <= 1'b1;
                    end
                    if (ARREADY) begin
                        ar_valid_q <= 1'b0;
                        r_ready_q  <= 1'b1;
                        state      <= DATA;
                    end
                end
                DATA: begin
                    if (RVALID) begin
                        r_ready_q <= 1'b0;
                        drop_q    <= 1'b0;
                        // A flush arriving with the data itself also marks it stale.
                        if (drop_q || flush_i) begin
                            state <= IDLE;
                        end else begin
                            inst_q  <= RDATA;
                            fault_q <= (RRESP != 2'b00);
                            state   <= DONE;
                        end
                    end else if (flush_i) begin
                        drop_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (flush_i || !pipe_stall_i) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state      <= IDLE;
                    ar_valid_q <= 1'b0;
                    r_ready_q  <= 1'b0;
                    drop_q     <= 1'b0;
                end
            endcase
        end
    end

    assign ARADDR         = addr_q;
    assign ARPROT         = 3'b100;
    assign ARVALID        = ar_valid_q;
    assign RREADY         = r_ready_q;
    assign inst_valid_o   = (state == DONE) & ~flush_i;
    assign fetch_stall_o  = (state != DONE) | pipe_stall_i;
    assign instruction_o  = fault_q ? RESET_INST : inst_q;
    assign fault_o        = fault_q & inst_valid_o;
    assign unused_pc_bits = ^pc_i[1:0];

endmodule

// File: tb/tb_if_fetch_master.sv
// Bench for if_fetch_master: scripted AXI slave plus a scoreboard of the
// instructions the fetch stage should consume, with cycle-level directed checks.
module tb_if_fetch_master;

    logic        ACLK;
    logic        ARESETn;
    logic [31:0] pc_i;
    logic        pipe_stall_i;
    logic        flush_i;
    logic [31:0] ARADDR;
    logic [2:0]  ARPROT;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY;
    logic [31:0] instruction_o;
    logic        inst_valid_o;
    logic        fetch_stall_o;
    logic        fault_o;

    if_fetch_master #(.RESET_INST(32'h00000013)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn), .pc_i(pc_i), .pipe_stall_i(pipe_stall_i),
        .flush_i(flush_i), .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID),
        .ARREADY(ARREADY), .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID),
        .RREADY(RREADY), .instruction_o(instruction_o), .inst_valid_o(inst_valid_o),
        .fetch_stall_o(fetch_stall_o), .fault_o(fault_o)
    );

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        int          ar_dly;
        int          r_dly;
        bit          early;
    } rsp_t;

    typedef struct {
        logic [31:0] inst;
        logic        fault;
    } exp_t;

    rsp_t rsp_q[$];
    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s (cycle %0d): got %h, expected %h", tag, cyc, act, exp);
        end
    endtask

    task automatic add_rsp(input logic [31:0] d, input logic [1:0] r, input int ad,
                           input int rd, input bit early, input bit expect_it);
        rsp_t s;
        exp_t e;
        s.data = d; s.resp = r; s.ar_dly = ad; s.r_dly = rd; s.early = early;
        rsp_q.push_back(s);
        if (expect_it) begin
            e.fault = (r != 2'b00);
            e.inst  = e.fault ? 32'h00000013 : d;
            exp_q.push_back(e);
        end
    endtask

    // Scripted slave, evaluated 2 time units after each rising edge.
    rsp_t cur;
    int   sphase = 0;
    int   cnt = 0;
    always begin
        @(posedge ACLK);
        #2;
        if (!ARESETn) begin
            // Leave a stale RVALID pending across reset release.
            ARREADY = 1'b0; RVALID = 1'b1; RDATA = 32'hBAD0BAD0; RRESP = 2'b00; sphase = 0;
        end else begin
            case (sphase)
                0: if (ARVALID) begin
                    RVALID = 1'b0;
                    if (rsp_q.size() > 0) cur = rsp_q.pop_front();
                    else begin
                        cur.data = 32'hFFFFFFFF; cur.resp = 2'b00;
                        cur.ar_dly = 0; cur.r_dly = 0; cur.early = 1'b0;
                    end
                    cnt = cur.ar_dly; sphase = 1;
                end
                2: begin ARREADY = 1'b0; RVALID = 1'b0; cnt = cur.r_dly; sphase = 3; end
                4: begin RVALID = 1'b0; sphase = 0; end
                default: ;
            endcase
            if (sphase == 1) begin
                if (cnt == 0) begin
                    ARREADY = 1'b1; sphase = 2;
                    if (cur.early) begin RVALID = 1'b1; RDATA = 32'hCAFE0000; RRESP = 2'b00; end
                end else cnt--;
            end else if (sphase == 3) begin
                if (cnt == 0) begin
                    RVALID = 1'b1; RDATA = cur.data; RRESP = cur.resp; sphase = 4;
                end else cnt--;
            end
        end
    end

    // Scoreboard: every instruction consumed by the fetch stage is popped and compared.
    always @(negedge ACLK) begin
        if (ARESETn && inst_valid_o && !pipe_stall_i) begin
            if (exp_q.size() == 0) chk("sb_unexpected_valid", 32'(inst_valid_o), 32'd0);
            else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_inst", instruction_o, e.inst);
                chk("sb_fault", 32'(fault_o), 32'(e.fault));
            end
        end
    end

    task automatic next();
        @(posedge ACLK);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        ARESETn = 1'b0;
        #1;
        chk("rst_arvalid", 32'(ARVALID), 32'd0);
        chk("rst_rready", 32'(RREADY), 32'd0);
        chk("rst_araddr", ARADDR, 32'h0);
        chk("rst_inst_valid", 32'(inst_valid_o), 32'd0);
        chk("rst_fetch_stall", 32'(fetch_stall_o), 32'd1);
        chk("rst_instruction", instruction_o, 32'h00000013);
        chk("rst_fault", 32'(fault_o), 32'd0);
        @(posedge ACLK);
        @(posedge ACLK);
        #1;
        ARESETn = 1'b1;
        cyc = 1;
    endtask

    // Runs cycles 1..deliv after a reset, checking valid/stall timing and the AR window.
    task automatic watch(input int deliv, input logic [31:0] addr, input int ar_first,
                         input int ar_last, input int fl_cyc,
                         input logic [31:0] pc1, input logic [31:0] pc2);
        for (int c = 1; c <= deliv; c++) begin
            flush_i = (c == fl_cyc);
            pc_i    = (fl_cyc != 0 && c > fl_cyc) ? pc2 : pc1;
            pipe_stall_i = 1'b0;
            @(negedge ACLK);
            chk("inst_valid", 32'(inst_valid_o), 32'(c == deliv));
            chk("fetch_stall", 32'(fetch_stall_o), 32'(c != deliv));
            if (c >= ar_first && c <= ar_last) begin
                chk("arvalid_held", 32'(ARVALID), 32'd1);
                chk("araddr", ARADDR, addr);
                chk("rready_in_addr", 32'(RREADY), 32'd0);
                chk("arprot", 32'(ARPROT), 32'd4);
            end
            if (c == ar_last + 1) begin
                chk("rready_in_data", 32'(RREADY), 32'd1);
                chk("arvalid_dropped", 32'(ARVALID), 32'd0);
            end
            next();
        end
        flush_i = 1'b1;
    endtask

    initial begin
        ARESETn = 1'b1; pc_i = 32'h0; pipe_stall_i = 1'b0; flush_i = 1'b1;
        ARREADY = 1'b0; RVALID = 1'b0; RDATA = 32'h0; RRESP = 2'b00;
        #2;

        // Zero-wait fetch from address 0.
        add_rsp(32'h00500093, 2'b00, 0, 0, 1'b0, 1'b1);
        do_reset();
        watch(4, 32'h0, 2, 2, 0, 32'h0, 32'h0);

        // ARREADY three cycles late.
        add_rsp(32'h00A00113, 2'b00, 3, 0, 1'b0, 1'b1);
        do_reset();
        watch(7, 32'h104, 2, 5, 0, 32'h104, 32'h0);

        // Flush during DATA drops the beat; refetch from the new, realigned PC.
        add_rsp(32'hDEADBEEF, 2'b00, 0, 2, 1'b0, 1'b0);
        add_rsp(32'h00108093, 2'b00, 0, 0, 1'b0, 1'b1);
        do_reset();
        watch(9, 32'h200, 7, 7, 3, 32'h80, 32'h203);

        // Error response with an early RVALID during the AR handshake.
        add_rsp(32'h12345678, 2'b10, 0, 0, 1'b1, 1'b1);
        do_reset();
        watch(4, 32'h10, 2, 2, 0, 32'h10, 32'h0);
        @(negedge ACLK);
        chk("fault_after_valid", 32'(fault_o), 32'd0);
        next();

        // Downstream stall held for three cycles in DONE.
        add_rsp(32'h00208113, 2'b00, 0, 0, 1'b0, 1'b1);
        do_reset();
        pc_i = 32'h40;
        for (int c = 1; c <= 8; c++) begin
            pipe_stall_i = (c >= 4 && c <= 6);
            flush_i = (c == 8);
            @(negedge ACLK);
            if (c >= 4 && c <= 7) begin
                chk("stall_valid", 32'(inst_valid_o), 32'd1);
                chk("stall_inst", instruction_o, 32'h00208113);
                chk("stall_fetch_stall", 32'(fetch_stall_o), 32'(c != 7));
            end
            if (c == 8) chk("stall_then_idle", 32'(inst_valid_o), 32'd0);
            next();
        end

        // Flush and stall together in DONE: flush wins and fetching resumes.
        add_rsp(32'h00000293, 2'b00, 0, 0, 1'b0, 1'b0);
        add_rsp(32'h00200113, 2'b00, 0, 0, 1'b0, 1'b1);
        do_reset();
        for (int c = 1; c <= 9; c++) begin
            pipe_stall_i = (c == 4);
            flush_i = (c == 4) || (c == 9);
            pc_i = (c >= 5) ? 32'h64 : 32'h60;
            @(negedge ACLK);
            if (c == 4) chk("flush_win_valid", 32'(inst_valid_o), 32'd0);
            if (c == 5) chk("flush_win_idle", 32'(ARVALID), 32'd0);
            if (c == 6) begin
                chk("flush_win_arvalid", 32'(ARVALID), 32'd1);
                chk("flush_win_araddr", ARADDR, 32'h64);
            end
            if (c == 8) chk("flush_win_deliver", 32'(inst_valid_o), 32'd1);
            next();
        end

        // Reset in DATA abandons the read; stale RVALID must not be taken.
        add_rsp(32'hBADBAD00, 2'b00, 0, 5, 1'b0, 1'b0);
        add_rsp(32'h00000513, 2'b00, 0, 0, 1'b0, 1'b1);
        do_reset();
        pc_i = 32'h300; flush_i = 1'b0; pipe_stall_i = 1'b0;
        next();
        next();
        @(negedge ACLK);
        chk("data_rready", 32'(RREADY), 32'd1);
        do_reset();
        watch(4, 32'h310, 2, 2, 0, 32'h310, 32'h0);
        next();

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/if_fetch_master.md
IF_FETCH_MASTER -- requirements
Module: if_fetch_master

Interface
REQ-001 Parameter RESET_INST, default 32'h00000013, SHALL be the instruction value driven after reset and on fault (NOP).
REQ-002 ACLK  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 ARESETn  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 pc_i  input  32  SHALL be the current PC from the fetch stage.
REQ-005 pipe_stall_i  input  1  SHALL be the downstream hazard stall.
REQ-006 flush_i  input  1  SHALL indicate a taken jump; the path being fetched is wrong.
REQ-007 ARADDR  output  32  SHALL be the AXI4-Lite read address.
REQ-008 ARPROT  output  3  SHALL be the AXI read protection, constant 3'b100 (instruction access).
REQ-009 ARVALID  output  1 / ARREADY  input  1  SHALL be the AXI read-address handshake.
REQ-010 RDATA  input  32 / RRESP  input  2 / RVALID  input  1 / RREADY  output  1  SHALL be the AXI read-data channel.
REQ-011 instruction_o  output  32  SHALL be the fetched instruction to the fetch stage.
REQ-012 inst_valid_o  output  1  SHALL be high when instruction_o is consumable this cycle.
REQ-013 fetch_stall_o  output  1  SHALL be the stall request to the fetch stage's PC register.
REQ-014 fault_o  output  1  SHALL flag a bus error on the delivered instruction.

Function
REQ-015 FSM states SHALL be IDLE, ADDR, DATA, DONE; one transaction outstanding at most.
REQ-016 IDLE: if flush_i=0, latch addr_q <= {pc_i[31:2],2'b00} and go to ADDR; if flush_i=1, stay IDLE and latch nothing.
REQ-017 ADDR: ARVALID=1, ARADDR=addr_q, stable until ARREADY; on ARVALID&ARREADY go to DATA.
REQ-018 ARVALID SHALL NOT deassert before the handshake, even on flush_i.
REQ-019 DATA: RREADY=1; on RVALID&RREADY capture RDATA into inst_q, fault_q <= (RRESP!=2'b00), and go to DONE; if drop_q=1, discard data, clear drop_q, and go to IDLE.
REQ-020 flush_i high in ADDR or DATA SHALL set drop_q; drop_q clears only at the R handshake or on reset.
REQ-021 DONE: inst_valid_o = ~flush_i; hold DONE while pipe_stall_i=1 and flush_i=0; otherwise go to IDLE.
REQ-022 fetch_stall_o = (state!=DONE) | pipe_stall_i; combinational.
REQ-023 instruction_o = inst_q, or RESET_INST when fault_q=1; fault_o = fault_q & inst_valid_o.
REQ-024 Minimum latency with zero-wait bus SHALL be 4 cycles per instruction (IDLE, ADDR, DATA, DONE); each wait cycle of ARREADY/RVALID adds one.
REQ-025 flush_i and pipe_stall_i together in DONE: flush wins; inst_valid_o=0 and the next state is IDLE.
REQ-026 Back-to-back: RVALID in the same cycle ARREADY is accepted SHALL be ignored (RREADY=0 in ADDR).

Reset
REQ-027 On ARESETn=0, immediately: state=IDLE, ARVALID=0, RREADY=0, ARADDR=0, inst_q=RESET_INST, fault_q=0, drop_q=0, inst_valid_o=0, fetch_stall_o=1.
REQ-028 Reset during ADDR/DATA SHALL abandon the transaction; no further handshake signals are driven until re-entry to ADDR.
REQ-029 The first address issued after reset SHALL be the pc_i value sampled in the first IDLE cycle after release.

Verification
REQ-030 Zero-wait slave, pc_i=0x0, RDATA=0x00500093 -> ARADDR=0x0 in cycle 2; inst_valid_o=1 and instruction_o=0x00500093 in cycle 4; fetch_stall_o=0 only in cycle 4.
REQ-031 ARREADY delayed 3 cycles, pc_i=0x104 -> ARVALID held with ARADDR=0x104 for 4 cycles; delivery 3 cycles later than in REQ-030.
REQ-032 flush_i pulsed in DATA, RDATA=0xDEADBEEF -> data dropped; inst_valid_o stays 0; next ARADDR equals new pc_i (e.g. 0x200).
REQ-033 RRESP=2'b10 -> in DONE, instruction_o=0x00000013 and fault_o=1 for exactly the valid cycle.
REQ-034 pipe_stall_i held 3 cycles in DONE -> inst_valid_o=1 and fetch_stall_o=1 for those cycles; instruction_o stable; IDLE follows release.
REQ-035 ARESETn low in DATA -> ARVALID=RREADY=0 asynchronously; after release, fetch restarts from pc_i with no stale RVALID accepted.
